// File: rtl/cpu_core_p.sv
// Small multi-cycle core: FETCH/EXEC/MEM/HALT sequencer over an 8x XLEN register file,
// 8 one-bit flags and a single shared word-addressed memory port.
module cpu_core_p #(
  parameter int XLEN = 64,
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  // Memory handshake: a transfer completes on the rising edge where mem_req && mem_ready;
  // mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until that edge.

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3} state_t;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_AND    = 6'd2;
  localparam logic [5:0] OP_OR     = 6'd3;
  localparam logic [5:0] OP_XOR    = 6'd4;
  localparam logic [5:0] OP_LDI    = 6'd5;
  localparam logic [5:0] OP_LOAD   = 6'd6;
  localparam logic [5:0] OP_STORE  = 6'd7;
  localparam logic [5:0] OP_CMPEQ  = 6'd8;
  localparam logic [5:0] OP_CMPLTU = 6'd9;
  localparam logic [5:0] OP_JMP    = 6'd10;
  localparam logic [5:0] OP_JZ     = 6'd11;
  localparam logic [5:0] OP_HALT   = 6'd63;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [63:0]       ir_q, ir_d;
  logic [XLEN-1:0]   rf_q [8];
  logic [XLEN-1:0]   rf_d [8];
  logic [7:0]        flag_q, flag_d;

  logic [5:0]        op;
  logic [2:0]        sa, sb, sd;
  logic              hl;
  logic [31:0]       imm;
  logic [XLEN-1:0]   ra, rb;
  logic [63:0]       ldi_hi;
  logic [ADDR_W-1:0] pc_inc, jmp_tgt;
  logic              hs, is_mem;
  logic              unused_ir;

  assign op      = ir_q[5:0];
  assign sa      = ir_q[8:6];
  assign sb      = ir_q[11:9];
  assign sd      = ir_q[14:12];
  assign hl      = ir_q[15];
  assign imm     = ir_q[63:32];
  assign ra      = rf_q[sa];
  assign rb      = rf_q[sb];
  assign ldi_hi  = {imm, rf_q[sd][31:0]};
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign jmp_tgt = ADDR_W'(imm);
  assign hs      = mem_req && mem_ready;
  assign is_mem  = (op == OP_LOAD) || (op == OP_STORE);
  assign unused_ir = ^ir_q[31:16];
  assign dbg_state = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flag_q  <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      rf_q    <= rf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (hs) state_d = S_EXEC;
      S_EXEC: begin
        if (is_mem) state_d = S_MEM;
        else if (op == OP_HALT) state_d = S_HALT;
        else state_d = S_FETCH;
      end
      S_MEM:   if (hs) state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates the fetch request so the bus is idle while reset is held.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = '0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: mem_req = !reset;
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(ra);
        if (op == OP_STORE) begin
          mem_we    = 1'b1;
          mem_wdata = rb;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    rf_d   = rf_q;
    flag_d = flag_q;
    case (state_q)
      S_FETCH: if (hs) ir_d = mem_rdata;
      S_EXEC: begin
        if (!is_mem && op != OP_HALT) pc_d = pc_inc;
        case (op)
          OP_ADD:    rf_d[sd] = ra + rb;
          OP_SUB:    rf_d[sd] = ra - rb;
          OP_AND:    rf_d[sd] = ra & rb;
          OP_OR:     rf_d[sd] = ra | rb;
          OP_XOR:    rf_d[sd] = ra ^ rb;
          OP_LDI:    rf_d[sd] = hl ? XLEN'(ldi_hi) : XLEN'(imm);
          OP_CMPEQ:  flag_d[sd] = (ra == rb);
          OP_CMPLTU: flag_d[sd] = (ra < rb);
          OP_JMP:    pc_d = jmp_tgt;
          OP_JZ:     if (!flag_q[sa]) pc_d = jmp_tgt;
          default: ;
        endcase
      end
      S_MEM: begin
        if (hs) begin
          pc_d = pc_inc;
          if (op == OP_LOAD) rf_d[sd] = mem_rdata[XLEN-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// Bench for cpu_core_p: behavioural memory, store scoreboard, a vector table of
// one-instruction programs and hand-written multi-cycle sequences.
module tb_cpu_core_p;
  localparam int XLEN = 64;
  localparam int ADDR_W = 64;
  localparam logic [1:0] ST_FETCH = 2'd0, ST_EXEC = 2'd1, ST_MEM = 2'd2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_req, mem_we, halted;
  logic              mem_ready = 1'b1;
  logic [1:0]        dbg_state;

  logic [63:0] mem [256];
  logic [63:0] exp_q [$];
  logic [7:0]  exp_a [$];
  int n_cmp = 0, n_bad = 0, store_cnt = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test

  always #5 clock = ~clock;
  assign mem_rdata = mem[mem_addr[7:0]];

  cpu_core_p #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
    .halted(halted), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory side: choose mem_ready for the coming edge, then commit a store that will complete.
  always @(negedge clock) begin
    if (rdy_mode == 0) mem_ready = 1'b1;
    else if (rdy_mode == 1) mem_ready = 1'($urandom_range(0, 1));
    #2;
    if (!reset && mem_req && mem_ready && mem_we) begin
      store_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_store: got addr %h data %h, expected no store", mem_addr, mem_wdata);
      end else begin
        check("store_addr", mem_addr, 64'(exp_a.pop_front()));
        check("store_data", 64'(mem_wdata), exp_q.pop_front());
      end
      mem[mem_addr[7:0]] = 64'(mem_wdata);
    end
  end

  function automatic logic [63:0] enc(input logic [5:0] op, input logic [2:0] sd, input logic [2:0] sa,
                                      input logic [2:0] sb, input logic hl, input logic [31:0] imm);
    logic [63:0] w;
    w = {imm, 32'b0};
    w[5:0] = op;
    w[8:6] = sa;
    w[11:9] = sb;
    w[14:12] = sd;
    w[15] = hl;
    return w;
  endfunction

  function automatic logic [63:0] ldi(input logic [2:0] rd, input logic hl, input logic [31:0] imm);
    return enc(6'd5, rd, 3'd0, 3'd0, hl, imm);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = enc(6'd63, 3'd0, 3'd0, 3'd0, 1'b0, 32'd0);
    exp_q.delete();
    exp_a.delete();
    store_cnt = 0;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [63:0] d);
    exp_a.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_FETCH));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_req", 64'(mem_req), 64'd1);
    check("post_rst_addr", mem_addr, 64'd0);
  endtask

  task automatic wait_halt(input string name);
    int i = 0;
    while (!halted && i < 500) begin
      @(negedge clock);
      #1;
      i++;
    end
    check({name, "_halted"}, 64'(halted), 64'd1);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [13];

  initial begin
    vecs[0]  = '{6'd0,  64'd5, 64'd5, 64'd10, "add_small"};
    vecs[1]  = '{6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "add_wrap"};
    vecs[2]  = '{6'd1,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, "sub_neg"};
    vecs[3]  = '{6'd2,  64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_1234_00FF, 64'hF000_F000_0000_00FF, "and"};
    vecs[4]  = '{6'd3,  64'h0000_0012_0000_0034, 64'h0000_FF00_0000_0000, 64'h0000_FF12_0000_0034, "or"};
    vecs[5]  = '{6'd4,  64'hFFFF_FFFF_0000_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_0F0F_0F0F, "xor"};
    vecs[6]  = '{6'd8,  64'd7, 64'd7, 64'd1, "cmpeq_eq"};
    vecs[7]  = '{6'd8,  64'd7, 64'd8, 64'd0, "cmpeq_ne"};
    vecs[8]  = '{6'd9,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "cmpltu_lt"};
    vecs[9]  = '{6'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "cmpltu_gt"};
    vecs[10] = '{6'd9,  64'd5, 64'd5, 64'd0, "cmpltu_eq"};
    vecs[11] = '{6'd50, 64'd1, 64'd2, 64'h0000_0000_0000_DEAD, "nop50"};
    vecs[12] = '{6'd1,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "sub_wrap"};

    // Vector table: load a, b, run one op, store the result (flag results via JZ).
    for (int i = 0; i < 13; i++) begin
      clear_mem();
      mem[0] = ldi(3'd1, 1'b0, vecs[i].a[31:0]);
      mem[1] = ldi(3'd1, 1'b1, vecs[i].a[63:32]);
      mem[2] = ldi(3'd2, 1'b0, vecs[i].b[31:0]);
      mem[3] = ldi(3'd2, 1'b1, vecs[i].b[63:32]);
      mem[4] = ldi(3'd3, 1'b0, 32'hDEAD);
      mem[5] = ldi(3'd4, 1'b0, 32'h80);
      mem[6] = ldi(3'd6, 1'b0, 32'd1);
      mem[7] = ldi(3'd7, 1'b0, 32'd0);
      if (vecs[i].op == 6'd8 || vecs[i].op == 6'd9) begin
        mem[8]  = enc(vecs[i].op, 3'd1, 3'd1, 3'd2, 1'b0, 32'd0);
        mem[9]  = enc(6'd11, 3'd0, 3'd1, 3'd0, 1'b0, 32'd12);
        mem[10] = enc(6'd7, 3'd0, 3'd4, 3'd6, 1'b0, 32'd0);
        mem[12] = enc(6'd7, 3'd0, 3'd4, 3'd7, 1'b0, 32'd0);
      end else begin
        mem[8] = enc(vecs[i].op, 3'd3, 3'd1, 3'd2, 1'b0, 32'h1234);
        mem[9] = enc(6'd7, 3'd0, 3'd4, 3'd3, 1'b0, 32'd0);
      end
      push_exp(8'h80, vecs[i].exp);
      rdy_mode = 1;
      do_reset();
      wait_halt(vecs[i].name);
    end

    // LDI r1,5 ; ADD r2,r1,r1 -> fetching pc 2 after four edges
    clear_mem();
    mem[0] = ldi(3'd1, 1'b0, 32'd5);
    mem[1] = enc(6'd0, 3'd2, 3'd1, 3'd1, 1'b0, 32'd0);
    mem[2] = ldi(3'd4, 1'b0, 32'h80);
    mem[3] = enc(6'd7, 3'd0, 3'd4, 3'd2, 1'b0, 32'd0);
    push_exp(8'h80, 64'd10);
    rdy_mode = 0;
    do_reset();
    repeat (4) @(negedge clock);
    #1;
    check("seqA_pc", mem_addr, 64'd2);
    check("seqA_state", 64'(dbg_state), 64'(ST_FETCH));
    check("seqA_req", 64'(mem_req), 64'd1);
    wait_halt("seqA");

    // LDI hi r0 ; ADD r0,r0,r0 wraps; f0 stays clear so JZ f0 is taken
    clear_mem();
    mem[0] = ldi(3'd0, 1'b1, 32'hFFFF_FFFF);
    mem[1] = enc(6'd0, 3'd0, 3'd0, 3'd0, 1'b0, 32'd0);
    mem[2] = ldi(3'd4, 1'b0, 32'h80);
    mem[3] = enc(6'd7, 3'd0, 3'd4, 3'd0, 1'b0, 32'd0);
    mem[4] = enc(6'd11, 3'd0, 3'd0, 3'd0, 1'b0, 32'd6);
    mem[6] = ldi(3'd5, 1'b0, 32'd1);
    mem[7] = enc(6'd7, 3'd0, 3'd4, 3'd5, 1'b0, 32'd0);
    push_exp(8'h80, 64'hFFFF_FFFE_0000_0000);
    push_exp(8'h80, 64'd1);
    rdy_mode = 1;
    do_reset();
    wait_halt("seqB");

    // STORE stalled three edges: request held stable, one write only
    clear_mem();
    mem[0] = ldi(3'd1, 1'b0, 32'h10);
    mem[1] = ldi(3'd2, 1'b0, 32'hAB);
    mem[2] = enc(6'd7, 3'd0, 3'd1, 3'd2, 1'b0, 32'd0);
    push_exp(8'h10, 64'hAB);
    rdy_mode = 2;
    mem_ready = 1'b1;
    do_reset();
    begin
      int n = 0;
      while (dbg_state != ST_MEM && n < 50) begin
        @(negedge clock);
        #1;
        n++;
      end
    end
    check("seqC_in_mem", 64'(dbg_state), 64'(ST_MEM));
    mem_ready = 1'b0;
    repeat (3) begin
      check("seqC_req", 64'(mem_req), 64'd1);
      check("seqC_we", 64'(mem_we), 64'd1);
      check("seqC_addr", mem_addr, 64'h10);
      check("seqC_wdata", 64'(mem_wdata), 64'hAB);
      @(negedge clock);
      #1;
    end
    check("seqC_still_mem", 64'(dbg_state), 64'(ST_MEM));
    check("seqC_no_early", 64'(store_cnt), 64'd0);
    mem_ready = 1'b1;
    wait_halt("seqC");
    check("seqC_one_write", 64'(store_cnt), 64'd1);

    // CMPEQ f3 then JZ not taken; CMPLTU f3 then JZ taken to 0x40
    clear_mem();
    mem[0] = ldi(3'd1, 1'b0, 32'd5);
    mem[1] = ldi(3'd4, 1'b0, 32'h80);
    mem[2] = enc(6'd8, 3'd3, 3'd1, 3'd1, 1'b0, 32'd0);
    mem[3] = enc(6'd11, 3'd0, 3'd3, 3'd0, 1'b0, 32'h40);
    mem[4] = ldi(3'd5, 1'b0, 32'h11);
    mem[5] = enc(6'd7, 3'd0, 3'd4, 3'd5, 1'b0, 32'd0);
    mem[6] = enc(6'd9, 3'd3, 3'd1, 3'd1, 1'b0, 32'd0);
    mem[7] = enc(6'd11, 3'd0, 3'd3, 3'd0, 1'b0, 32'h40);
    mem[8] = ldi(3'd5, 1'b0, 32'h22);
    mem[9] = enc(6'd7, 3'd0, 3'd4, 3'd5, 1'b0, 32'd0);
    mem[8'h40] = ldi(3'd5, 1'b0, 32'h33);
    mem[8'h41] = enc(6'd7, 3'd0, 3'd4, 3'd5, 1'b0, 32'd0);
    push_exp(8'h80, 64'h11);
    push_exp(8'h80, 64'h33);
    rdy_mode = 1;
    do_reset();
    wait_halt("seqD");

    // Reset during a stalled LOAD: bus drops at once, destination never written
    clear_mem();
    mem[0] = ldi(3'd3, 1'b0, 32'h77);
    mem[1] = ldi(3'd1, 1'b0, 32'h90);
    mem[2] = enc(6'd6, 3'd3, 3'd1, 3'd0, 1'b0, 32'd0);
    mem[8'h90] = 64'h5555;
    rdy_mode = 2;
    mem_ready = 1'b1;
    do_reset();
    begin
      int n = 0;
      while (dbg_state != ST_MEM && n < 50) begin
        @(negedge clock);
        #1;
        n++;
      end
    end
    mem_ready = 1'b0;
    check("seqE_in_mem", 64'(dbg_state), 64'(ST_MEM));
    check("seqE_req", 64'(mem_req), 64'd1);
    check("seqE_we", 64'(mem_we), 64'd0);
    check("seqE_addr", mem_addr, 64'h90);
    @(negedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("seqE_req_drop", 64'(mem_req), 64'd0);
    check("seqE_state", 64'(dbg_state), 64'(ST_FETCH));
    clear_mem();
    mem[0] = ldi(3'd4, 1'b0, 32'h80);
    mem[1] = enc(6'd7, 3'd0, 3'd4, 3'd3, 1'b0, 32'd0);
    push_exp(8'h80, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("seqE_refetch_req", 64'(mem_req), 64'd1);
    check("seqE_refetch_addr", mem_addr, 64'd0);
    rdy_mode = 1;
    wait_halt("seqE");

    // HALT: halted on the edge after its EXEC, then bus idle for 20 cycles
    clear_mem();
    mem[0] = ldi(3'd1, 1'b0, 32'd3);
    mem[1] = enc(6'd50, 3'd1, 3'd1, 3'd1, 1'b0, 32'h1234);
    rdy_mode = 0;
    do_reset();
    repeat (5) @(negedge clock);
    #1;
    check("seqF_not_yet", 64'(halted), 64'd0);
    @(negedge clock);
    #1;
    check("seqF_halted", 64'(halted), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      check("seqF_hold_halted", 64'(halted), 64'd1);
      check("seqF_hold_noreq", 64'(mem_req), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion within 90000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/cpu_core_p.md
CPU_CORE_P -- requirements
Module: cpu_core_p

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath and register width, legal values 32..64.
REQ-002 SHALL have parameter ADDR_W, default 64: memory address width in words.
REQ-003 SHALL have parameter RESET_PC, default 0: fetch address after reset.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port mem_addr, output, ADDR_W: word address of the current transfer.
REQ-007 SHALL have port mem_wdata, output, XLEN: store data.
REQ-008 SHALL have port mem_rdata, input, 64: fetched instruction or load data, with load using bits [XLEN-1:0].
REQ-009 SHALL have port mem_req, output, 1: transfer request.
REQ-010 SHALL have port mem_we, output, 1: 1 = write, 0 = read.
REQ-011 SHALL have port mem_ready, input, 1: transfer completes on a rising edge where mem_req and mem_ready are both 1.
REQ-012 SHALL have port halted, output, 1: core stopped.

Function
REQ-013 SHALL hold 8 registers r0..r7 of XLEN bits, 8 one-bit flags f0..f7, a program counter pc (ADDR_W) and an instruction register ir (64).
REQ-014 SHALL decode ir as: op = [5:0], sa = [8:6], sb = [11:9], sd = [14:12], hl = [15], imm = [63:32].
REQ-015 SHALL implement states FETCH, EXEC, MEM and HALT, with the following transitions:
- FETCH to EXEC on handshake, with ir <= mem_rdata.
- EXEC to MEM for LOAD and STORE.
- EXEC to HALT for the HALT op.
- EXEC to FETCH otherwise.
- MEM to FETCH on handshake.
- HALT is terminal until reset.
REQ-016 SHALL, in FETCH, drive mem_req=1, mem_we=0, mem_addr=pc, and hold these stable until the handshake.
REQ-017 SHALL assert mem_req only in FETCH and MEM, and SHALL wait indefinitely while mem_ready=0.
REQ-018 SHALL implement the following ops; unlisted ops are NOPs:
- 0 ADD: rd = ra + rb.
- 1 SUB: rd = ra - rb.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 LDI: hl=0 gives rd = zero-extended imm; hl=1 gives rd = {imm, rd[31:0]} truncated to XLEN.
- 6 LOAD: rd = mem[ra].
- 7 STORE: mem[ra] = rb.
- 8 CMPEQ: fd = (ra==rb).
- 9 CMPLTU: fd = (ra<rb), unsigned.
- 10 JMP: pc = imm.
- 11 JZ: pc = imm if fa==0.
- 63 HALT.
REQ-019 SHALL wrap arithmetic modulo 2^XLEN, and SHALL produce no carry or overflow flags.
REQ-020 SHALL set pc to pc+1 (wrapping at 2^ADDR_W) for every non-taken instruction, and SHALL zero-extend or truncate jump targets to ADDR_W.
REQ-021 SHALL, for LOAD and STORE in MEM, drive mem_addr = ra truncated to ADDR_W, drive mem_we=1 for STORE only, and drive mem_wdata = rb.
REQ-022 SHALL write rd on the LOAD handshake edge, and SHALL advance pc on that same edge.
REQ-023 SHALL drive mem_wdata = 0 whenever it is not in a STORE MEM cycle.
REQ-024 SHALL take 2 cycles per ALU, compare or jump instruction and 3 cycles per LOAD/STORE when mem_ready is held at 1.
REQ-025 SHALL allow sd == sa or sd == sb, with the read using the pre-instruction value.
REQ-026 SHALL make HALT assert halted on the next edge, with mem_req=0 thereafter.

Reset
REQ-027 SHALL, on reset assertion and independent of clock, set:
- state = FETCH, pc = RESET_PC, ir = 0.
- all registers and flags = 0.
- mem_req = 0, mem_we = 0, mem_wdata = 0, halted = 0.
REQ-028 SHALL abandon any pending transfer when reset is asserted mid-transfer.
REQ-029 SHALL, after reset deasserts, assert mem_req with mem_addr=RESET_PC on the first rising edge.

Verification
REQ-030 SHALL verify LDI r1,5 then ADD r2,r1,r1 with mem_ready=1 -> r2=10 after 4 cycles, and pc=2.
REQ-031 SHALL verify LDI r0,0xFFFFFFFF (hl=1) then ADD r0,r0,r0 at XLEN=64 -> r0=0xFFFFFFFE_00000000, wrapping with no flag set.
REQ-032 SHALL verify STORE with ra=0x10, rb=0xAB and mem_ready held at 0 for 3 cycles -> mem_req/mem_we/mem_addr=0x10/mem_wdata=0xAB stable through the wait, with exactly one write completing.
REQ-033 SHALL verify CMPEQ f3,r1,r1 then JZ on f3 to 0x40 -> not taken, pc=+1; then CMPLTU f3,r1,r1 and JZ f3 to 0x40 -> pc=0x40.
REQ-034 SHALL verify reset asserted while in MEM during a LOAD -> mem_req falls immediately, r-dest is unchanged, and the next fetch is at RESET_PC.
REQ-035 SHALL verify HALT -> halted=1 and mem_req=0 for 20 subsequent cycles, and opcode 50 executes as a NOP.
